// File: rtl/booth_mul_seq_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : booth_mul_seq_if
// Description : Start/busy/done handshake bundle for the sequential Booth
//               multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
interface booth_mul_seq_if #(
    parameter int WIDTH = 32
);
    logic                   start;
    logic                   signed_mode;
    logic [WIDTH-1:0]       a;
    logic [WIDTH-1:0]       b;
    logic                   busy;
    logic                   done;
    logic [2*WIDTH-1:0]     product;

    modport master (
        output start, signed_mode, a, b,
        input  busy, done, product
    );

    modport slave (
        input  start, signed_mode, a, b,
        output busy, done, product
    );
endinterface
`default_nettype wire

// File: rtl/booth_mul_seq.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : booth_mul_seq
// Description : Iterative WIDTH x WIDTH Booth multiplier, one shared adder,
//               signed/unsigned at runtime. BOOTH_MUL_RADIX4_EN selects
//               radix-4 recoding (default build is radix-2).
// Revision    : 1.0 - initial release
// ============================================================================
module booth_mul_seq #(
    parameter int WIDTH = 32
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
    booth_mul_seq_if.slave bus
);

`ifdef BOOTH_MUL_RADIX4_EN
    localparam int c_QW = WIDTH + 2;
    localparam int c_AW = WIDTH + 3;
    localparam int c_N  = WIDTH / 2 + 1;
    localparam int c_SH = 2;
`else
    localparam int c_QW = WIDTH + 1;
    localparam int c_AW = WIDTH + 2;
    localparam int c_N  = WIDTH + 1;
    localparam int c_SH = 1;
`endif
    localparam int c_TW = c_AW + c_QW + 1;
    localparam int c_CW = $clog2(c_N + 1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    logic [1:0]             r_state;
    logic [c_CW-1:0]        r_cnt;
    logic [c_AW-1:0]        r_acc;
    logic [c_AW-1:0]        r_m;
    logic [c_QW-1:0]        r_q;
    logic                   r_qm1;
    logic                   r_busy;
    logic                   r_done;
    logic [2*WIDTH-1:0]     r_product;

    logic [c_AW-1:0]        w_a_ext;
    logic [c_QW-1:0]        w_b_ext;
    logic [c_AW-1:0]        w_addend;
    logic [c_AW-1:0]        w_sum;
    logic signed [c_TW-1:0] w_shift;

    // Extension by one or more bits lets unsigned operands with MSB=1 be
    // treated as positive signed values by the Booth recoder.
    assign w_a_ext = {{(c_AW-WIDTH){bus.signed_mode & bus.a[WIDTH-1]}}, bus.a};
    assign w_b_ext = {{(c_QW-WIDTH){bus.signed_mode & bus.b[WIDTH-1]}}, bus.b};

    always_comb begin
        w_addend = '0;
`ifdef BOOTH_MUL_RADIX4_EN
        case ({r_q[1], r_q[0], r_qm1})
            3'b001, 3'b010: w_addend = r_m;
            3'b011:         w_addend = r_m << 1;
            3'b100:         w_addend = -(r_m << 1);
            3'b101, 3'b110: w_addend = -r_m;
            default:        w_addend = '0;
        endcase
`else
        case ({r_q[0], r_qm1})
            2'b01:   w_addend = r_m;
            2'b10:   w_addend = -r_m;
            default: w_addend = '0;
        endcase
`endif
    end

    assign w_sum   = r_acc + w_addend;
    assign w_shift = $signed({w_sum, r_q, r_qm1}) >>> c_SH;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_ST_IDLE;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_m       <= '0;
            r_q       <= '0;
            r_qm1     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_product <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_ST_RUN: begin
                    if (r_cnt != '0) begin
                        r_acc <= w_shift[c_TW-1 -: c_AW];
                        r_q   <= w_shift[c_QW:1];
                        r_qm1 <= w_shift[0];
                        r_cnt <= r_cnt - c_CW'(1);
                    end else begin
                        // Counter exhausted: {acc, Q} now holds the full product.
                        r_product <= (2*WIDTH)'({r_acc, r_q});
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_state   <= c_ST_DONE;
                    end
                end
                default: begin
                    if (bus.start) begin
                        r_m     <= w_a_ext;
                        r_q     <= w_b_ext;
                        r_acc   <= '0;
                        r_qm1   <= 1'b0;
                        r_cnt   <= c_CW'(c_N);
                        r_busy  <= 1'b1;
                        r_state <= c_ST_RUN;
                    end else begin
                        r_state <= c_ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.product = r_product;

endmodule
`default_nettype wire
